// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-slot inputs, forwarding sources, hazard controls and the EX-side outputs.
// The stage is the slave; whatever drives decode and observes EX is the master.
interface id_ex_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
);
    logic              id_valid;
    logic [RA_W-1:0]   id_rs;
    logic [RA_W-1:0]   id_rt;
    logic [RA_W-1:0]   id_rd_dest;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [4:0]        id_shamt;
    logic [3:0]        id_alu_control;
    logic              id_alu_src;
    logic              id_uses_rt;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_mem_to_reg;

    logic              exmem_reg_write;
    logic [RA_W-1:0]   exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_reg_write;
    logic [RA_W-1:0]   memwb_rd;
    logic [DATA_W-1:0] memwb_result;

    logic              flush;
    logic              hold;

    logic [DATA_W-1:0] ALU_reg_1;
    logic [DATA_W-1:0] ALU_reg_2;
    logic [3:0]        ALU_control;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] ex_store_data;
    logic              ex_valid;
    logic [RA_W-1:0]   ex_dest;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic              stall_out;

    modport master (
        output id_valid, id_rs, id_rt, id_rd_dest, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_alu_control, id_alu_src, id_uses_rt, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write,
               memwb_rd, memwb_result, flush, hold,
        input  ALU_reg_1, ALU_reg_2, ALU_control, shamt, ex_store_data, ex_valid, ex_dest,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall_out
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd_dest, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_alu_control, id_alu_src, id_uses_rt, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write,
               memwb_rd, memwb_result, flush, hold,
        output ALU_reg_1, ALU_reg_2, ALU_control, shamt, ex_store_data, ex_valid, ex_dest,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall_out
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use hazard detection.
// A bubble (flush or load-use) clears the whole stage so a killed slot can never forward or write.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);

    logic              r_valid;
    logic [RA_W-1:0]   r_rs;
    logic [RA_W-1:0]   r_rt;
    logic [RA_W-1:0]   r_dest;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_shamt;
    logic [3:0]        r_alu_control;
    logic              r_alu_src;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;

    logic              w_load_use;
    logic              w_wb_hit_rs;
    logic              w_wb_hit_rt;
    logic [DATA_W-1:0] w_cap_rs_data;
    logic [DATA_W-1:0] w_cap_rt_data;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    assign w_load_use = r_valid & r_mem_read & (r_dest != '0) & bus.id_valid &
                        ((r_dest == bus.id_rs) | (bus.id_uses_rt & (r_dest == bus.id_rt)));

    // Register file writes at the end of WB, so the decode read may be stale by one cycle.
    assign w_wb_hit_rs   = bus.memwb_reg_write & (bus.memwb_rd != '0) & (bus.memwb_rd == bus.id_rs);
    assign w_wb_hit_rt   = bus.memwb_reg_write & (bus.memwb_rd != '0) & (bus.memwb_rd == bus.id_rt);
    assign w_cap_rs_data = w_wb_hit_rs ? bus.memwb_result : bus.id_rs_data;
    assign w_cap_rt_data = w_wb_hit_rt ? bus.memwb_result : bus.id_rt_data;

    always_ff @(posedge clk) begin
        if (reset || bus.flush || (!bus.hold && w_load_use)) begin
            r_valid       <= 1'b0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_dest        <= '0;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
            r_shamt       <= '0;
            r_alu_control <= '0;
            r_alu_src     <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
        end else if (!bus.hold) begin
            r_valid       <= bus.id_valid;
            r_rs          <= bus.id_rs;
            r_rt          <= bus.id_rt;
            r_dest        <= bus.id_rd_dest;
            r_rs_data     <= w_cap_rs_data;
            r_rt_data     <= w_cap_rt_data;
            r_imm         <= bus.id_imm;
            r_shamt       <= bus.id_shamt;
            r_alu_control <= bus.id_alu_control;
            r_alu_src     <= bus.id_alu_src;
            r_reg_write   <= bus.id_reg_write & bus.id_valid;
            r_mem_read    <= bus.id_mem_read & bus.id_valid;
            r_mem_write   <= bus.id_mem_write & bus.id_valid;
            r_mem_to_reg  <= bus.id_mem_to_reg & bus.id_valid;
        end
    end

    // EX/MEM is the younger producer, so it is checked first.
    always_comb begin
        w_fwd_rs = r_rs_data;
        if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rs)) begin
            w_fwd_rs = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rs)) begin
            w_fwd_rs = bus.memwb_result;
        end
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rt)) begin
            w_fwd_rt = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rt)) begin
            w_fwd_rt = bus.memwb_result;
        end
    end

    assign bus.ALU_reg_1     = w_fwd_rs;
    assign bus.ALU_reg_2     = r_alu_src ? r_imm : w_fwd_rt;
    assign bus.ex_store_data = w_fwd_rt;
    assign bus.ALU_control   = r_alu_control;
    assign bus.shamt         = r_shamt;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_dest       = r_dest;
    assign bus.ex_reg_write  = r_reg_write;
    assign bus.ex_mem_read   = r_mem_read;
    assign bus.ex_mem_write  = r_mem_write;
    assign bus.ex_mem_to_reg = r_mem_to_reg;
    assign bus.stall_out     = (w_load_use | bus.hold) & ~bus.flush;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, WB bypass, load-use bubble,
// register 0, flush/hold interaction and reset during a stall.
module tb_id_ex_stage;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    id_ex_stage_if #(.DATA_W(32), .RA_W(5)) bus ();

    id_ex_stage #(.DATA_W(32), .RA_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_id();
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd_dest = 0;
        bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0; bus.id_shamt = 0;
        bus.id_alu_control = 0; bus.id_alu_src = 0; bus.id_uses_rt = 0;
        bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1;
        clear_id();
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
        bus.flush = 0; bus.hold = 0;
        tick();
        tick();
        reset = 0;
        #1;
        check("rst_valid", 32'(bus.ex_valid), 0);
        check("rst_aluctl", 32'(bus.ALU_control), 0);
        check("rst_op1", bus.ALU_reg_1, 0);
        check("rst_op2", bus.ALU_reg_2, 0);
        check("rst_store", bus.ex_store_data, 0);
        check("rst_regwr", 32'(bus.ex_reg_write), 0);
        check("rst_stall", 32'(bus.stall_out), 0);

        // Plain capture
        bus.id_valid = 1; bus.id_rs = 1; bus.id_rt = 2; bus.id_rd_dest = 3;
        bus.id_rs_data = 32'h11; bus.id_rt_data = 32'h22; bus.id_imm = 32'h5;
        bus.id_shamt = 7; bus.id_alu_control = 4'h2; bus.id_uses_rt = 1; bus.id_reg_write = 1;
        tick();
        check("cap_op1", bus.ALU_reg_1, 32'h11);
        check("cap_op2", bus.ALU_reg_2, 32'h22);
        check("cap_aluctl", 32'(bus.ALU_control), 2);
        check("cap_shamt", 32'(bus.shamt), 7);
        check("cap_dest", 32'(bus.ex_dest), 3);
        check("cap_valid", 32'(bus.ex_valid), 1);
        check("cap_regwr", 32'(bus.ex_reg_write), 1);

        // EX/MEM forward to rs
        bus.id_rs = 3; bus.id_rt = 5; bus.id_rd_dest = 6;
        bus.id_rs_data = 32'h33; bus.id_rt_data = 32'h55;
        bus.exmem_reg_write = 1; bus.exmem_rd = 3; bus.exmem_result = 32'h10;
        tick();
        check("exmem_fwd_op1", bus.ALU_reg_1, 32'h10);
        check("exmem_fwd_op2", bus.ALU_reg_2, 32'h55);

        // Both later stages match rt: EX/MEM wins, then MEM/WB alone
        bus.exmem_rd = 5; bus.exmem_result = 32'hA;
        bus.memwb_reg_write = 1; bus.memwb_rd = 5; bus.memwb_result = 32'hB;
        #1;
        check("prio_op2", bus.ALU_reg_2, 32'hA);
        check("prio_store", bus.ex_store_data, 32'hA);
        check("prio_op1", bus.ALU_reg_1, 32'h33);
        bus.exmem_reg_write = 0;
        #1;
        check("memwb_fwd_op2", bus.ALU_reg_2, 32'hB);

        // WB->ID bypass at capture, immediate operand select
        bus.id_rs = 8; bus.id_rs_data = 32'h88; bus.id_rt = 6; bus.id_rt_data = 32'h66;
        bus.id_alu_src = 1; bus.id_imm = 32'h1234;
        bus.memwb_rd = 6; bus.memwb_result = 32'h99;
        tick();
        bus.memwb_reg_write = 0;
        #1;
        check("imm_op2", bus.ALU_reg_2, 32'h1234);
        check("wb_bypass_store", bus.ex_store_data, 32'h99);
        check("imm_op1", bus.ALU_reg_1, 32'h88);

        // Load-use: lw $4 then add using $4
        bus.id_rs = 1; bus.id_rs_data = 32'h100; bus.id_rt = 4; bus.id_rd_dest = 4;
        bus.id_mem_read = 1; bus.id_mem_to_reg = 1; bus.id_alu_src = 1; bus.id_imm = 0;
        bus.id_uses_rt = 0;
        tick();
        check("lw_memrd", 32'(bus.ex_mem_read), 1);
        check("lw_memtoreg", 32'(bus.ex_mem_to_reg), 1);
        bus.id_rs = 4; bus.id_rs_data = 32'hDEAD; bus.id_rt = 7; bus.id_rt_data = 32'h70;
        bus.id_rd_dest = 9; bus.id_uses_rt = 1; bus.id_mem_read = 0; bus.id_mem_to_reg = 0;
        bus.id_alu_src = 0;
        #1;
        check("lu_stall", 32'(bus.stall_out), 1);
        tick();
        check("lu_bubble_valid", 32'(bus.ex_valid), 0);
        check("lu_bubble_regwr", 32'(bus.ex_reg_write), 0);
        check("lu_bubble_memrd", 32'(bus.ex_mem_read), 0);
        check("lu_stall_clear", 32'(bus.stall_out), 0);
        bus.memwb_reg_write = 1; bus.memwb_rd = 4; bus.memwb_result = 32'h77;
        tick();
        check("lu_fwd_op1", bus.ALU_reg_1, 32'h77);
        check("lu_fwd_op2", bus.ALU_reg_2, 32'h70);
        check("lu_valid", 32'(bus.ex_valid), 1);
        bus.memwb_reg_write = 0;

        // Register 0 never forwards and never causes a load-use stall
        bus.id_rs = 0; bus.id_rs_data = 0; bus.id_rt = 0; bus.id_rt_data = 0;
        bus.id_rd_dest = 0; bus.id_mem_read = 1;
        bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.exmem_result = 32'hFFFF;
        tick();
        check("r0_op1", bus.ALU_reg_1, 0);
        bus.id_mem_read = 0;
        #1;
        check("r0_nostall", 32'(bus.stall_out), 0);
        tick();
        bus.exmem_reg_write = 0;

        // Flush overrides hold
        bus.flush = 1; bus.hold = 1;
        #1;
        check("flush_hold_stall", 32'(bus.stall_out), 0);
        tick();
        check("flush_valid", 32'(bus.ex_valid), 0);
        check("flush_regwr", 32'(bus.ex_reg_write), 0);
        bus.flush = 0; bus.hold = 0;

        // Hold freezes the stage
        bus.id_rs = 2; bus.id_rt = 3; bus.id_rd_dest = 12; bus.id_alu_control = 4'h6;
        bus.id_shamt = 3;
        tick();
        check("pre_hold_dest", 32'(bus.ex_dest), 12);
        bus.hold = 1; bus.id_rd_dest = 13; bus.id_alu_control = 4'h1;
        #1;
        check("hold_stall", 32'(bus.stall_out), 1);
        tick();
        check("hold_dest", 32'(bus.ex_dest), 12);
        check("hold_aluctl", 32'(bus.ALU_control), 6);
        check("hold_valid", 32'(bus.ex_valid), 1);
        bus.hold = 0;

        // Reset while load-use stall is active
        bus.id_rd_dest = 4; bus.id_mem_read = 1; bus.id_rs = 1; bus.id_rs_data = 32'h5;
        tick();
        bus.id_rs = 4; bus.id_mem_read = 0; bus.id_rd_dest = 9;
        #1;
        check("rs_stall_pre", 32'(bus.stall_out), 1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        check("rs_valid", 32'(bus.ex_valid), 0);
        check("rs_aluctl", 32'(bus.ALU_control), 0);
        check("rs_memrd", 32'(bus.ex_mem_read), 0);
        check("rs_op1", bus.ALU_reg_1, 0);
        check("rs_op2", bus.ALU_reg_2, 0);
        check("rs_stall", 32'(bus.stall_out), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
